// File: rtl/mult_sched_pkg.sv
// rtl/mult_sched_pkg.sv - shared types and requester pick function for the multiplier scheduler
package mult_sched_pkg;

    localparam int MAX_REQ = 8;
    localparam int ID_W    = $clog2(MAX_REQ);

    typedef struct packed {
        logic            vld;
        logic [ID_W-1:0] id;
    } tag_t;

    typedef struct packed {
        logic            found;
        logic [ID_W-1:0] idx;
    } pick_t;

    // Round-robin starts after ptr and wraps at num; fixed priority takes the lowest index.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                      input logic [ID_W-1:0]    ptr,
                                      input logic               fixed,
                                      input int                 num);
        pick_t           p;
        int              j;
        logic [ID_W-1:0] jj;
        p = '0;
        for (int k = 1; k <= MAX_REQ; k++) begin
            if (fixed) j = k - 1;
            else       j = (int'(ptr) + k) % num;
            jj = ID_W'(j);
            if (!p.found && k <= num && req[jj]) begin
                p.found = 1'b1;
                p.idx   = jj;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/mult_share_scheduler_rr_arbiter.sv
// rtl/mult_share_scheduler_rr_arbiter.sv - combinational requester pick with registered rr pointer
module rr_arbiter
    import mult_sched_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               cfg_fixed_pri,
    input  logic [NUM_REQ-1:0] req_valid,
    output logic [NUM_REQ-1:0] grant,
    output logic               gnt_xfer,
    output logic [ID_W-1:0]    gnt_idx
);

    logic [ID_W-1:0] r_ptr;
    pick_t           w_pick;

    always_comb begin
        w_pick   = rr_pick(MAX_REQ'(req_valid), r_ptr, cfg_fixed_pri, NUM_REQ);
        gnt_xfer = w_pick.found && en && !rst;
        gnt_idx  = w_pick.idx;
        grant    = gnt_xfer ? (NUM_REQ'(1) << w_pick.idx) : '0;
    end

    // Pointer tracks the last winner in both modes so a switch back to round-robin is fair.
    always_ff @(posedge clk) begin
        if (rst)           r_ptr <= ID_W'(NUM_REQ - 1);
        else if (gnt_xfer) r_ptr <= w_pick.idx;
    end

endmodule

// File: rtl/mult_share_scheduler.sv
// rtl/mult_share_scheduler.sv - shares one pipelined multiplier between requesters, routes products by tag
module mult_share_scheduler
    import mult_sched_pkg::*;
#(
    parameter int DATAWIDTH    = 8,
    parameter int NUM_REQ      = 4,
    parameter int MULT_LATENCY = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en,
    input  logic                           cfg_fixed_pri,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*DATAWIDTH-1:0]   req_a,
    input  logic [NUM_REQ*DATAWIDTH-1:0]   req_b,
    output logic [NUM_REQ-1:0]             res_valid,
    output logic [2*DATAWIDTH-1:0]         res_z,
    output logic                           mul_i_valid,
    output logic [DATAWIDTH-1:0]           mul_a,
    output logic [DATAWIDTH-1:0]           mul_b,
    input  logic                           mul_o_valid,
    input  logic [2*DATAWIDTH-1:0]         mul_z,
    output logic                           idle,
    output logic                           err_tag_mismatch
);

    localparam int CNT_W  = $clog2(MULT_LATENCY + 3);
    localparam int MASK_W = $clog2(MULT_LATENCY + 2);

    logic                   w_xfer;
    logic [ID_W-1:0]        w_idx;
    logic [DATAWIDTH-1:0]   w_a;
    logic [DATAWIDTH-1:0]   w_b;
    tag_t                   w_tag_out;

    logic                   r_mul_valid;
    logic [DATAWIDTH-1:0]   r_mul_a;
    logic [DATAWIDTH-1:0]   r_mul_b;
    tag_t                   r_issue_tag;
    tag_t                   r_tag [MULT_LATENCY];
    logic [NUM_REQ-1:0]     r_res_valid;
    logic [2*DATAWIDTH-1:0] r_res_z;
    logic                   r_err;
    logic [MASK_W-1:0]      r_mask;
    logic [CNT_W-1:0]       r_count;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .cfg_fixed_pri (cfg_fixed_pri),
        .req_valid     (req_valid),
        .grant         (req_ready),
        .gnt_xfer      (w_xfer),
        .gnt_idx       (w_idx)
    );

    assign w_a       = req_a[w_idx*DATAWIDTH +: DATAWIDTH];
    assign w_b       = req_b[w_idx*DATAWIDTH +: DATAWIDTH];
    assign w_tag_out = r_tag[MULT_LATENCY-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mul_valid <= 1'b0;
            r_mul_a     <= '0;
            r_mul_b     <= '0;
            r_issue_tag <= '0;
        end else begin
            r_mul_valid <= w_xfer;
            r_mul_a     <= w_xfer ? w_a : '0;
            r_mul_b     <= w_xfer ? w_b : '0;
            r_issue_tag <= '{vld: w_xfer, id: w_idx};
        end
    end

    // Issue register plus MULT_LATENCY stages lines the tag up with mul_o_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < MULT_LATENCY; k++) r_tag[k] <= '0;
        end else begin
            r_tag[0] <= r_issue_tag;
            for (int k = 1; k < MULT_LATENCY; k++) r_tag[k] <= r_tag[k-1];
        end
    end

    // After reset the multiplier may still emit stale products; ignore its output until it has drained.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_res_valid <= '0;
            r_res_z     <= '0;
            r_err       <= 1'b0;
            r_mask      <= MASK_W'(MULT_LATENCY + 1);
        end else begin
            r_res_valid <= '0;
            if (r_mask != '0) begin
                r_mask <= r_mask - MASK_W'(1);
            end else begin
                if (w_tag_out.vld) begin
                    r_res_valid <= NUM_REQ'(1) << w_tag_out.id;
                    r_res_z     <= mul_z;
                end
                if (mul_o_valid != w_tag_out.vld) r_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            case ({w_xfer, |r_res_valid})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign mul_i_valid      = r_mul_valid;
    assign mul_a            = r_mul_a;
    assign mul_b            = r_mul_b;
    assign res_valid        = r_res_valid;
    assign res_z            = r_res_z;
    assign idle             = (r_count == '0);
    assign err_tag_mismatch = r_err;

endmodule
